// File: rtl/fc_pipe_sequencer.sv
// Sequencer for a 32-input fully-connected neuron pipeline: accepts a frame of vectors,
// moves a valid token through the 7 datapath stages and stalls everything on output back-pressure.
module fc_pipe_sequencer #(
  parameter int NUM_VECTORS = 4096,
  parameter int CNT_W       = 13,
  parameter int N_STAGES    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                fc_valid_in,
  output logic [N_STAGES-1:0] fc_valid_pipe,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    out_idx,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t              state_q, state_d;
  logic [N_STAGES:0]   tok_q, tok_d;
  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]    out_idx_q, out_idx_d;
  logic                en;
  logic                acc;
  logic                consume;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready of the same port, and in_ready is low whenever the pipe is stalled.
  always_comb begin
    state_d   = state_q;
    tok_d     = tok_q;
    in_cnt_d  = in_cnt_q;
    out_idx_d = out_idx_q;

    en      = ~(tok_q[N_STAGES] & ~out_ready);
    in_ready = (state_q == S_RUN) & en;
    acc     = in_valid & in_ready;
    consume = tok_q[N_STAGES] & out_ready;

    // Token moves one stage per enabled cycle; a bubble shifts in when nothing is accepted
    if (en) tok_d = {tok_q[N_STAGES-1:0], acc};
    if (acc) in_cnt_d = in_cnt_q + CNT_W'(1);
    if (consume) out_idx_d = out_idx_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (acc && in_cnt_q == LAST_IDX) state_d = S_DRAIN;
      S_DRAIN: if (consume && out_idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE: begin
        state_d   = S_IDLE;
        in_cnt_d  = '0;
        out_idx_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tok_q     <= '0;
      in_cnt_q  <= '0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      tok_q     <= tok_d;
      in_cnt_q  <= in_cnt_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign fc_valid_in   = acc;
  assign fc_valid_pipe = {N_STAGES{en}} & tok_q[N_STAGES-1:0];
  assign out_valid     = tok_q[N_STAGES];
  assign out_idx       = out_idx_q;
  assign busy          = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fc_pipe_sequencer.sv
// Directed bench for fc_pipe_sequencer: a 4-vector instance for timing/stall/reset cases
// and a 64-vector instance driven with random handshakes against an in-order scoreboard.
module tb_fc_pipe_sequencer;

  logic        clk;
  logic        rst;

  logic        a_start, a_in_valid, a_in_ready, a_fc_valid_in, a_out_valid, a_out_ready;
  logic [6:0]  a_fc_valid_pipe;
  logic [12:0] a_out_idx;
  logic        a_busy, a_done;
  logic [1:0]  a_dbg_state;

  logic        b_start, b_in_valid, b_in_ready, b_fc_valid_in, b_out_valid, b_out_ready;
  logic [6:0]  b_fc_valid_pipe;
  logic [12:0] b_out_idx;
  logic        b_busy, b_done;
  logic [1:0]  b_dbg_state;

  int          n_assert;
  int          n_fail;
  logic [12:0] exp_q[$];

  fc_pipe_sequencer #(.NUM_VECTORS(4), .CNT_W(13), .N_STAGES(7)) u_dut (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .fc_valid_in(a_fc_valid_in), .fc_valid_pipe(a_fc_valid_pipe), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_idx(a_out_idx), .busy(a_busy), .done(a_done),
    .dbg_state(a_dbg_state)
  );

  fc_pipe_sequencer #(.NUM_VECTORS(64), .CNT_W(13), .N_STAGES(7)) u_dut64 (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .fc_valid_in(b_fc_valid_in), .fc_valid_pipe(b_fc_valid_pipe), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_idx(b_out_idx), .busy(b_busy), .done(b_done),
    .dbg_state(b_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Clean 4-vector frame, out_ready=1, in_valid=1: cycle i counts falling edges after start.
  task automatic frame_clean(input string name);
    logic [6:0] ep;
    next_cycle();
    a_start = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
    #1;
    check({name, "_idle_in_ready"}, 32'(a_in_ready), 32'd0);
    for (int i = 1; i <= 14; i++) begin
      next_cycle();
      a_start = 1'b0;
      #1;
      for (int k = 0; k < 7; k++) ep[k] = (i >= 2 + k) && (i <= 5 + k);
      check($sformatf("%s_in_ready_c%0d", name, i), 32'(a_in_ready), 32'(i <= 4));
      check($sformatf("%s_fc_valid_in_c%0d", name, i), 32'(a_fc_valid_in), 32'(i <= 4));
      check($sformatf("%s_pipe_c%0d", name, i), 32'(a_fc_valid_pipe), 32'(ep));
      check($sformatf("%s_out_valid_c%0d", name, i), 32'(a_out_valid), 32'(i >= 9 && i <= 12));
      if (i >= 9 && i <= 12)
        check($sformatf("%s_out_idx_c%0d", name, i), 32'(a_out_idx), 32'(i - 9));
      check($sformatf("%s_done_c%0d", name, i), 32'(a_done), 32'(i == 13));
      check($sformatf("%s_busy_c%0d", name, i), 32'(a_busy), 32'(i <= 12));
    end
    check({name, "_idx_cleared"}, 32'(a_out_idx), 32'd0);
  endtask

  initial begin
    int n_acc;
    int n_res;
    int cyc;
    bit done_seen;

    n_assert = 0; n_fail = 0;
    rst = 1'b1;
    a_start = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_start = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;

    // reset state
    repeat (2) next_cycle();
    #1;
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
    check("rst_fc_valid_in", 32'(a_fc_valid_in), 32'd0);
    check("rst_pipe", 32'(a_fc_valid_pipe), 32'd0);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_idx", 32'(a_out_idx), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_state", 32'(a_dbg_state), 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // 1: clean frame, latency 7, throughput 1/cycle
    frame_clean("t1");

    // 2: output stall of 5 cycles with the first result at the output
    next_cycle();
    a_start = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      next_cycle();
      a_start     = 1'b0;
      a_in_valid  = (i <= 2) || (i >= 9);
      a_out_ready = !(i >= 9 && i <= 13);
      #1;
      check($sformatf("t2_in_ready_c%0d", i), 32'(a_in_ready),
            32'((i <= 8) || i == 14 || i == 15));
      check($sformatf("t2_out_valid_c%0d", i), 32'(a_out_valid),
            32'((i >= 9 && i <= 15) || i == 22 || i == 23));
      if (i >= 9 && i <= 13) begin
        check($sformatf("t2_stall_pipe_c%0d", i), 32'(a_fc_valid_pipe), 32'd0);
        check($sformatf("t2_stall_idx_c%0d", i), 32'(a_out_idx), 32'd0);
      end
      if (i == 14) check("t2_resume_pipe", 32'(a_fc_valid_pipe), 32'h40);
      if (i == 15) check("t2_idx1_c15", 32'(a_out_idx), 32'd1);
      if (i == 22) check("t2_idx2_c22", 32'(a_out_idx), 32'd2);
      if (i == 23) check("t2_idx3_c23", 32'(a_out_idx), 32'd3);
      check($sformatf("t2_done_c%0d", i), 32'(a_done), 32'(i == 24));
      check($sformatf("t2_busy_c%0d", i), 32'(a_busy), 32'(i <= 23));
    end

    // 3+4: in_valid 1,0,1,0 with start pulsed in RUN (c2) and DRAIN (c10)
    next_cycle();
    a_start = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      next_cycle();
      a_start    = (i == 2) || (i == 10);
      a_in_valid = (i <= 8) && (i % 2 == 1);
      #1;
      check($sformatf("t3_in_ready_c%0d", i), 32'(a_in_ready), 32'(i <= 7));
      check($sformatf("t3_fc_valid_in_c%0d", i), 32'(a_fc_valid_in),
            32'(i <= 7 && i % 2 == 1));
      check($sformatf("t3_pipe0_c%0d", i), 32'(a_fc_valid_pipe[0]),
            32'(i >= 2 && i <= 8 && i % 2 == 0));
      check($sformatf("t3_pipe6_c%0d", i), 32'(a_fc_valid_pipe[6]),
            32'(i >= 8 && i <= 14 && i % 2 == 0));
      check($sformatf("t3_out_valid_c%0d", i), 32'(a_out_valid),
            32'(i >= 9 && i <= 15 && i % 2 == 1));
      if (i >= 9 && i <= 15)
        check($sformatf("t3_out_idx_c%0d", i), 32'(a_out_idx), 32'((i - 8) / 2));
      check($sformatf("t3_done_c%0d", i), 32'(a_done), 32'(i == 16));
      check($sformatf("t3_busy_c%0d", i), 32'(a_busy), 32'(i <= 15));
    end

    // 5: reset with 3 tokens in flight, then a clean frame
    next_cycle();
    a_start = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      a_start    = 1'b0;
      a_in_valid = (i <= 3);
    end
    #1;
    check("t5_pipe_before_rst", 32'(a_fc_valid_pipe), 32'h0e);
    rst = 1'b1;
    #1;
    check("t5_rst_pipe", 32'(a_fc_valid_pipe), 32'd0);
    check("t5_rst_in_ready", 32'(a_in_ready), 32'd0);
    check("t5_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("t5_rst_busy", 32'(a_busy), 32'd0);
    check("t5_rst_done", 32'(a_done), 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      #1;
      check($sformatf("t5_quiet_done_c%0d", i), 32'(a_done), 32'd0);
      check($sformatf("t5_quiet_ov_c%0d", i), 32'(a_out_valid), 32'd0);
    end
    frame_clean("t5");

    // 6: random handshakes on the 64-vector instance, in-order scoreboard
    next_cycle();
    b_start = 1'b1;
    n_acc = 0; n_res = 0; cyc = 0; done_seen = 1'b0;
    while (n_res < 64 && cyc < 4000) begin
      next_cycle();
      b_start     = 1'b0;
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (b_in_valid && b_in_ready) begin
        exp_q.push_back(13'(n_acc));
        n_acc++;
      end
      if (b_out_valid && b_out_ready) begin
        if (exp_q.size() == 0) check("t6_unexpected_result", 32'(b_out_idx), 32'hffff_ffff);
        else check($sformatf("t6_idx_r%0d", n_res), 32'(b_out_idx), 32'(exp_q.pop_front()));
        n_res++;
      end
      check($sformatf("t6_inflight_c%0d", cyc), 32'(exp_q.size() <= 8), 32'd1);
      cyc++;
    end
    check("t6_results", 32'(n_res), 32'd64);
    check("t6_accepted", 32'(n_acc), 32'd64);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    next_cycle();
    #1;
    done_seen = b_done;
    check("t6_done", 32'(done_seen), 32'd1);
    next_cycle();
    #1;
    check("t6_idle_busy", 32'(b_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
